// File: rtl/dmem_bridge_pkg.sv
// Shared definitions for the data-memory bridge: FSM encoding and defaults.
package dmem_defs;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DONE = 2'd2,
    S_ERR  = 2'd3
  } state_t;

  localparam int          TIMEOUT_DEF = 16;
  localparam logic [31:0] ERR_RDATA   = 32'h0000_0000;

endpackage

// File: rtl/dmem_bridge_timeout_counter.sv
// REQ-phase watchdog: counts enabled cycles, flags the last allowed one.
module timeout_counter #(
  parameter int CNT_W   = 5,
  parameter int TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             enable,
  output logic [CNT_W-1:0] count,
  output logic             expired
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)      r_cnt <= '0;
    else if (clear)  r_cnt <= '0;
    else if (enable) r_cnt <= r_cnt + CNT_W'(1);
  end

  assign count   = r_cnt;
  // Asserted during the TIMEOUT-th REQ cycle, so bus_req lasts exactly TIMEOUT cycles.
  assign expired = (r_cnt == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/dmem_bridge.sv
// Data-memory bridge: turns single-cycle load/store strobes into a req/ack bus
// transaction, stalling the core until it completes, errors or times out.
module dmem_bridge
  import dmem_defs::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF,
  parameter int CNT_W   = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memread,
  input  logic        memwrite,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] readdata,
  output logic        stall,
  output logic        err,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack
);

  state_t           r_state, w_next;
  logic             r_bus_req, r_bus_we;
  logic [31:0]      r_bus_addr, r_bus_wdata, r_rdata;
  logic             w_valid, w_bad, w_timeout, w_expired, w_cnt_clr, w_in_req;
  logic [CNT_W-1:0] w_cnt;

  assign w_valid  = (memread ^ memwrite) && (addr[1:0] == 2'b00);
  assign w_bad    = (memread | memwrite) && !w_valid;
  assign w_in_req = (r_state == S_REQ);
  // Expiry with a zero count would mean the counter never ran; never abort on that.
  assign w_timeout = w_expired && (w_cnt != '0);
  assign w_cnt_clr = w_in_req && (bus_ack || w_timeout);

  timeout_counter #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) u_wdog (
    .clk     (clk),
    .reset   (reset),
    .clear   (w_cnt_clr),
    .enable  (w_in_req),
    .count   (w_cnt),
    .expired (w_expired)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_valid)    w_next = S_REQ;
        else if (w_bad) w_next = S_ERR;
      end
      S_REQ: begin
        // Ack beats a simultaneous timeout.
        if (bus_ack)        w_next = S_DONE;
        else if (w_timeout) w_next = S_ERR;
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    stall = 1'b0;
    err   = 1'b0;
    case (r_state)
      S_IDLE:  stall = w_valid;
      S_REQ:   stall = 1'b1;
      S_ERR:   err   = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_bus_req   <= 1'b0;
      r_bus_we    <= 1'b0;
      r_bus_addr  <= '0;
      r_bus_wdata <= '0;
      r_rdata     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_valid) begin
            r_bus_req   <= 1'b1;
            r_bus_we    <= memwrite;
            r_bus_addr  <= {addr[31:2], 2'b00};
            r_bus_wdata <= wdata;
          end else if (w_bad) begin
            r_rdata <= ERR_RDATA;
          end
        end
        S_REQ: begin
          if (bus_ack) begin
            r_bus_req <= 1'b0;
            if (!r_bus_we) r_rdata <= bus_rdata;
          end else if (w_timeout) begin
            r_bus_req <= 1'b0;
            r_rdata   <= ERR_RDATA;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus_req   = r_bus_req;
  assign bus_we    = r_bus_we;
  assign bus_addr  = r_bus_addr;
  assign bus_wdata = r_bus_wdata;
  assign readdata  = r_rdata;

endmodule

// File: tb/tb_dmem_bridge.sv
// Directed bench for dmem_bridge: inputs change on the falling edge, outputs
// are checked 1 ns later, well clear of the rising edge.
module tb_dmem_bridge;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        memread = 1'b0, memwrite = 1'b0, bus_ack = 1'b0;
  logic [31:0] addr = '0, wdata = '0, bus_rdata = '0;
  logic [31:0] readdata, bus_addr, bus_wdata;
  logic        stall, err, bus_req, bus_we;

  int nchk = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  dmem_bridge #(.TIMEOUT(16), .CNT_W(5)) dut (
    .clk       (clk),
    .reset     (rst_n),
    .memread   (memread),
    .memwrite  (memwrite),
    .addr      (addr),
    .wdata     (wdata),
    .readdata  (readdata),
    .stall     (stall),
    .err       (err),
    .bus_req   (bus_req),
    .bus_we    (bus_we),
    .bus_addr  (bus_addr),
    .bus_wdata (bus_wdata),
    .bus_rdata (bus_rdata),
    .bus_ack   (bus_ack)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(negedge clk);
  endtask

  initial begin
    int reqs;

    // reset state
    nxt(); #1;
    chk("rst_bus_req", 32'(bus_req), 32'd0);
    chk("rst_stall",   32'(stall),   32'd0);
    chk("rst_err",     32'(err),     32'd0);
    chk("rst_rdata",   readdata,     32'h0);
    chk("rst_baddr",   bus_addr,     32'h0);
    nxt(); rst_n = 1'b1;

    // load, ack on first REQ cycle
    nxt(); memread = 1'b1; addr = 32'h10; bus_rdata = 32'hCAFE_F00D; #1;
    chk("ld_stall_idle", 32'(stall),   32'd1);
    chk("ld_req_idle",   32'(bus_req), 32'd0);
    nxt(); bus_ack = 1'b1; #1;
    chk("ld_req",   32'(bus_req), 32'd1);
    chk("ld_addr",  bus_addr,     32'h10);
    chk("ld_we",    32'(bus_we),  32'd0);
    chk("ld_stall", 32'(stall),   32'd1);
    nxt(); bus_ack = 1'b0; #1;
    chk("ld_done_stall", 32'(stall),   32'd0);
    chk("ld_done_req",   32'(bus_req), 32'd0);
    chk("ld_done_rdata", readdata,     32'hCAFE_F00D);
    chk("ld_done_err",   32'(err),     32'd0);
    nxt(); memread = 1'b0; #1;
    chk("ld_idle_stall", 32'(stall), 32'd0);

    // store, ack on third REQ cycle
    nxt(); memwrite = 1'b1; addr = 32'h20; wdata = 32'h1234_5678; #1;
    chk("st_stall_idle", 32'(stall), 32'd1);
    for (int i = 0; i < 3; i++) begin
      nxt(); bus_ack = (i == 2); #1;
      chk("st_req",   32'(bus_req), 32'd1);
      chk("st_we",    32'(bus_we),  32'd1);
      chk("st_wdata", bus_wdata,    32'h1234_5678);
      chk("st_addr",  bus_addr,     32'h20);
      chk("st_stall", 32'(stall),   32'd1);
    end
    nxt(); bus_ack = 1'b0; memwrite = 1'b0; #1;
    chk("st_done_stall", 32'(stall),   32'd0);
    chk("st_done_req",   32'(bus_req), 32'd0);
    chk("st_done_rdata", readdata,     32'hCAFE_F00D);

    // misaligned load
    nxt(); memread = 1'b1; addr = 32'h13; #1;
    chk("mis_stall", 32'(stall),   32'd0);
    chk("mis_req",   32'(bus_req), 32'd0);
    nxt(); memread = 1'b0; #1;
    chk("mis_err",   32'(err),     32'd1);
    chk("mis_rdata", readdata,     32'h0);
    chk("mis_req2",  32'(bus_req), 32'd0);
    chk("mis_stall2", 32'(stall),  32'd0);
    nxt(); #1;
    chk("mis_err_end", 32'(err), 32'd0);

    // timeout: count REQ cycles, bounded
    nxt(); memread = 1'b1; addr = 32'h40; bus_rdata = 32'h5555_AAAA; #1;
    reqs = 0;
    for (int i = 0; i < 40; i++) begin
      nxt(); #1;
      if (!bus_req) break;
      reqs++;
      if (!stall) begin
        nerr++; nchk++;
        $error("FAIL to_stall: observed 0 expected 1 in REQ cycle %0d", reqs);
      end
    end
    memread = 1'b0;
    chk("to_req_cycles", 32'(reqs), 32'd16);
    chk("to_err",        32'(err),  32'd1);
    chk("to_stall",      32'(stall), 32'd0);
    nxt(); #1;
    chk("to_err_end", 32'(err), 32'd0);
    nxt(); bus_ack = 1'b1;
    nxt(); bus_ack = 1'b0; #1;
    chk("late_ack_req",   32'(bus_req), 32'd0);
    chk("late_ack_err",   32'(err),     32'd0);
    chk("late_ack_rdata", readdata,     32'h0);
    chk("late_ack_stall", 32'(stall),   32'd0);

    // reset during second REQ cycle of a store
    nxt(); memwrite = 1'b1; addr = 32'h30; wdata = 32'hAAAA_5555;
    nxt(); nxt(); #1;
    chk("rr_req_before", 32'(bus_req), 32'd1);
    memwrite = 1'b0; rst_n = 1'b0; #1;
    chk("rr_req",   32'(bus_req), 32'd0);
    chk("rr_we",    32'(bus_we),  32'd0);
    chk("rr_addr",  bus_addr,     32'h0);
    chk("rr_wdata", bus_wdata,    32'h0);
    chk("rr_stall", 32'(stall),   32'd0);
    chk("rr_err",   32'(err),     32'd0);
    nxt(); rst_n = 1'b1; bus_ack = 1'b1; bus_rdata = 32'h7777_7777;
    nxt(); bus_ack = 1'b0; #1;
    chk("rr_ack_req",   32'(bus_req), 32'd0);
    chk("rr_ack_rdata", readdata,     32'h0);
    chk("rr_ack_err",   32'(err),     32'd0);

    // both strobes, then a normal load
    nxt(); memread = 1'b1; memwrite = 1'b1; addr = 32'h8; #1;
    chk("both_stall", 32'(stall), 32'd0);
    nxt(); memread = 1'b0; memwrite = 1'b0; #1;
    chk("both_err", 32'(err),     32'd1);
    chk("both_req", 32'(bus_req), 32'd0);
    nxt(); memread = 1'b1; addr = 32'h8; bus_rdata = 32'hDEAD_BEEF; #1;
    chk("both_ld_stall", 32'(stall), 32'd1);
    nxt(); bus_ack = 1'b1; #1;
    chk("both_ld_req",  32'(bus_req), 32'd1);
    chk("both_ld_addr", bus_addr,     32'h8);
    nxt(); bus_ack = 1'b0; memread = 1'b0; #1;
    chk("both_ld_rdata", readdata,   32'hDEAD_BEEF);
    chk("both_ld_stall2", 32'(stall), 32'd0);
    chk("both_ld_err",   32'(err),   32'd0);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule

// File: doc/dmem_bridge.md
Name: dmem_bridge

Overview:
- Data-memory bridge downstream of the single-cycle MIPS datapath.
- Consumes the datapath's ALU address, store data and the memread/memwrite strobes from the controller.
- Runs a req/ack transaction on an external memory bus and returns readdata to the datapath.
- Asserts stall to freeze the PC register and register-file writes until the access completes; flags misaligned, illegal and timed-out accesses.

Parameters:
- TIMEOUT, 16, number of REQ cycles without bus_ack before the access is aborted (minimum 2).
- CNT_W, 5, width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- memread  input  1  load request from the controller.
- memwrite  input  1  store request from the controller.
- addr  input  32  byte address (datapath aluout).
- wdata  input  32  store data (datapath writedata).
- readdata  output  32  load result to the datapath result mux.
- stall  output  1  high = datapath must hold PC and suppress regwrite.
- err  output  1  one-cycle pulse on a rejected or aborted access.
- bus_req  output  1  bus request, registered.
- bus_we  output  1  1 = write, 0 = read, registered.
- bus_addr  output  32  word-aligned bus address, registered.
- bus_wdata  output  32  bus write data, registered.
- bus_rdata  input  32  bus read data; valid when bus_ack = 1.
- bus_ack  input  1  single-cycle completion from memory.

Behaviour:
- Reset (reset = 0, asynchronous):
  - State goes to IDLE.
  - bus_req, bus_we, err go to 0; bus_addr, bus_wdata, readdata go to 0; timeout counter goes to 0.
  - Any transaction in flight is abandoned. A bus_ack arriving after reset release while in IDLE is ignored.
- States: IDLE, REQ, DONE, ERR.
- IDLE:
  - Request = memread | memwrite.
  - Valid request (exactly one strobe high and addr[1:0] = 0):
    - stall = 1 combinationally in the same cycle.
    - Latch bus_we = memwrite, bus_addr = {addr[31:2], 2'b00}, bus_wdata = wdata.
    - Set bus_req = 1 and go to REQ.
  - Misaligned (addr[1:0] != 0) or both strobes high:
    - No bus access; stall = 0.
    - Go to ERR, which pulses err on the following cycle.
  - No request: stall = 0.
- REQ:
  - bus_req = 1 and stall = 1; bus_addr, bus_we and bus_wdata are held stable.
  - The counter increments each cycle.
  - If bus_ack = 1: clear bus_req; if a read, register readdata <= bus_rdata; clear the counter; go to DONE.
  - If there is no ack and the counter = TIMEOUT-1: clear bus_req and the counter; go to ERR.
  - bus_ack and timeout in the same cycle: ack wins.
- DONE:
  - stall = 0; readdata holds the loaded value; the datapath commits in this cycle.
  - memread/memwrite are ignored in this cycle, because the same instruction is still presented.
  - Go to IDLE next cycle.
- ERR:
  - err = 1 for exactly this cycle; stall = 0; readdata = 0.
  - Go to IDLE.
- readdata holds its last value except when updated by a read ack or cleared in ERR. A write ack does not change readdata.
- bus_ack outside REQ is ignored.
- Latency: with ack on the first REQ cycle, a load or store occupies 3 cycles (IDLE-detect, REQ, DONE). Each extra ack-wait cycle adds 1.
- Stall is never asserted in DONE or ERR, so the core always advances after at most TIMEOUT+2 cycles.

Decomposition:
- Shared package/header dmem_defs holds:
  - State encoding constants: IDLE = 2'd0, REQ = 2'd1, DONE = 2'd2, ERR = 2'd3.
  - The default TIMEOUT value.
  - The ERR readdata value (32'h0).
- One natural sub-module, timeout_counter:
  - Ports: clk, reset, clear, enable, CNT_W-bit count, expired flag.
  - Same asynchronous active-low reset.
  - Instantiated once for the REQ watchdog.

Test Plan:
- Load, ack on first REQ cycle: memread = 1, addr = 32'h0000_0010, bus_rdata = 32'hCAFE_F00D. Expect bus_req high for 1 cycle with bus_addr = 32'h10, bus_we = 0; stall = 1 for 2 cycles; readdata = 32'hCAFE_F00D in DONE; err stays 0.
- Store with 3-cycle ack delay: memwrite = 1, addr = 32'h20, wdata = 32'h1234_5678. Expect bus_we = 1 and bus_wdata = 32'h1234_5678 stable for 3 REQ cycles; stall = 1 for 4 cycles; readdata unchanged.
- Misaligned access: memread = 1, addr = 32'h0000_0013. Expect bus_req to stay 0, err = 1 on the next cycle, readdata = 0, stall = 0 throughout.
- Timeout: memread = 1, addr = 32'h40, bus_ack never asserted, TIMEOUT = 16. Expect bus_req high for exactly 16 cycles, then err pulse, then IDLE. A late bus_ack two cycles afterwards changes nothing.
- Reset mid-transaction: assert reset = 0 during the 2nd REQ cycle. Expect bus_req = 0 immediately (without waiting for a clock edge), state IDLE, all outputs 0. A bus_ack after release is ignored.
- Both strobes high: memread = memwrite = 1, addr = 32'h8. Expect no bus access and an err pulse. The next aligned load completes normally.
